// File: rtl/adapter_axi_stream_2_block_fifo.sv
// AXI-Stream slave that fills one side of a ping-pong block FIFO per block.
// tuser[0] rides in the FIFO word MSB so frame-start markers survive the FIFO.
module adapter_axi_stream_2_block_fifo #(
    parameter int DATA_WIDTH   = 24,
    parameter int STROBE_WIDTH = DATA_WIDTH / 8,
    parameter int USE_KEEP     = 0
) (
    input  logic                  i_axi_clk,
    input  logic                  rst,
    input  logic [3:0]            i_axi_user,
    input  logic [DATA_WIDTH-1:0] i_axi_data,
    input  logic                  i_axi_last,
    input  logic                  i_axi_valid,
    output logic                  o_axi_ready,
    input  logic [1:0]            i_block_fifo_rdy,
    output logic [1:0]            o_block_fifo_act,
    input  logic [23:0]           i_block_fifo_size,
    output logic                  o_block_fifo_stb,
    output logic [DATA_WIDTH:0]   o_block_fifo_data,
    output logic [31:0]           o_debug
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READY   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  act_q, act_d;
    logic [23:0] count_q, count_d;
    logic        last_side_q, last_side_d;

    logic [24:0] count_inc;
    logic        room;
    logic        block_done;
    logic        unused_bits;

    // 25-bit increment so a full 0xFFFFFF-word block cannot wrap the compare.
    assign count_inc  = {1'b0, count_q} + 25'd1;
    assign room       = (count_q < i_block_fifo_size);
    assign block_done = i_axi_last || (count_inc >= {1'b0, i_block_fifo_size});

    assign o_axi_ready       = (state_q == ST_READY) && (act_q != 2'b00) && room;
    assign o_block_fifo_stb  = i_axi_valid && o_axi_ready;
    assign o_block_fifo_data = {i_axi_user[0], i_axi_data};
    assign o_block_fifo_act  = act_q;

    assign o_debug = {8'h00, count_q[7:0], 5'h00, last_side_q, i_axi_valid,
                      o_axi_ready, i_block_fifo_rdy, act_q, {2'b00, state_q}};

    assign unused_bits = ^{i_axi_user[3:1], (STROBE_WIDTH != 0), (USE_KEEP != 0)};

    always_ff @(posedge i_axi_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            act_q       <= 2'b00;
            count_q     <= 24'd0;
            last_side_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            count_q     <= count_d;
            last_side_q <= last_side_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        count_d     = count_q;
        last_side_d = last_side_q;
        case (state_q)
            ST_IDLE: begin
                if ((act_q == 2'b00) && (i_block_fifo_rdy != 2'b00)) begin
                    count_d = 24'd0;
                    state_d = ST_READY;
                    case (i_block_fifo_rdy)
                        2'b01:   act_d = 2'b01;
                        2'b10:   act_d = 2'b10;
                        default: begin
                            // Both sides free: alternate away from the last contended pick.
                            act_d       = last_side_q ? 2'b01 : 2'b10;
                            last_side_d = ~last_side_q;
                        end
                    endcase
                end
            end
            ST_READY: begin
                if (o_block_fifo_stb) begin
                    count_d = count_inc[23:0];
                    if (block_done) begin
                        act_d   = 2'b00;
                        state_d = ST_RELEASE;
                    end
                end else if (!room) begin
                    act_d   = 2'b00;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // One idle cycle gives the FIFO time to refresh its rdy flags.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                act_d   = 2'b00;
            end
        endcase
    end

endmodule
